// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU with an optional iterative multiplier/divider.
// Define ALU_MULDIV_MULDIV_EN to build the MUL/MULHU/DIVU/REMU engine; without it, opcodes 11xx return 0.
module alu_muldiv #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   operacion_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] salida_o,
  output logic         valid_o,
  output logic         c_o,
  output logic         set_o,
  output logic         setunsigned_o,
  output logic         busy_o
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] w_shamt;
  logic [N:0]    w_sum;
  logic [N:0]    w_diff;
  logic          w_lt;
  logic          w_ltu;
  logic [N-1:0]  w_aluRes;
  logic          w_aluCarry;
  logic          w_flagUpd;
  logic          w_multi;
  logic          w_accept;
  logic          w_multiDone;
  logic [N-1:0]  w_multiRes;

  logic [N-1:0]  r_result;
  logic          r_valid;
  logic          r_c;
  logic          r_set;
  logic          r_setu;

  assign w_shamt = b_i[SW-1:0];
  assign w_sum   = {1'b0, a_i} + {1'b0, b_i};
  // Subtraction as a + ~b + 1, so carry-out = 1 means no borrow.
  assign w_diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
  assign w_lt    = $signed(a_i) < $signed(b_i);
  assign w_ltu   = a_i < b_i;

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = w_diff[N];
    w_flagUpd  = 1'b0;
    case (operacion_i)
      4'b0000: w_aluRes = a_i & b_i;
      4'b0001: w_aluRes = a_i | b_i;
      4'b0010: begin
        w_aluRes   = w_sum[N-1:0];
        w_aluCarry = w_sum[N];
        w_flagUpd  = 1'b1;
      end
      4'b0011: begin
        w_aluRes  = w_diff[N-1:0];
        w_flagUpd = 1'b1;
      end
      4'b0100: begin
        w_aluRes  = {{(N-1){1'b0}}, w_lt};
        w_flagUpd = 1'b1;
      end
      4'b0101: begin
        w_aluRes  = {{(N-1){1'b0}}, w_ltu};
        w_flagUpd = 1'b1;
      end
      4'b0110: w_aluRes = ~(a_i | b_i);
      4'b0111: w_aluRes = a_i ^ b_i;
      4'b1000: w_aluRes = a_i << w_shamt;
      4'b1001: w_aluRes = a_i >> w_shamt;
      4'b1010: w_aluRes = $signed(a_i) >>> w_shamt;
      default: w_aluRes = '0;
    endcase
  end

`ifdef ALU_MULDIV_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] w_accNext;
  logic [2*N-1:0] w_mulNext;
  logic [2*N-1:0] w_divNext;
  logic [N-1:0]   r_opnd;
  logic [1:0]     r_op;
  logic [SW-1:0]  r_count;
  logic [N:0]     w_mulSum;
  logic [N:0]     w_divShift;
  logic [N:0]     w_divTrial;

  assign w_multi = operacion_i[3] & operacion_i[2];

  // Shift-add step: multiplier sits in the low half of the accumulator and drains out to the right.
  assign w_mulSum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : {(N+1){1'b0}});
  assign w_mulNext = {w_mulSum, r_acc[N-1:1]};

  // Restoring step: quotient bits shift into the low half as dividend bits shift out.
  assign w_divShift = r_acc[2*N-1:N-1];
  assign w_divTrial = w_divShift - {1'b0, r_opnd};
  assign w_divNext  = w_divTrial[N] ? {w_divShift[N-1:0], r_acc[N-2:0], 1'b0}
                                    : {w_divTrial[N-1:0], r_acc[N-2:0], 1'b1};

  assign w_accNext   = r_op[1] ? w_divNext : w_mulNext;
  assign w_multiDone = (r_state == S_RUN) && (r_count == '0);
  assign w_multiRes  = r_op[0] ? w_accNext[2*N-1:N] : w_accNext[N-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_accept && w_multi) w_stateNext = S_RUN;
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (r_count == '0) w_stateNext = S_DONE;
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_opnd  <= '0;
      r_op    <= '0;
      r_count <= '0;
    end else if (w_accept && w_multi) begin
      r_op    <= operacion_i[1:0];
      r_opnd  <= operacion_i[1] ? b_i : a_i;
      r_acc   <= operacion_i[1] ? {{N{1'b0}}, a_i} : {{N{1'b0}}, b_i};
      r_count <= SW'(N-1);
    end else if (r_state == S_RUN) begin
      r_acc   <= w_accNext;
      r_count <= r_count - SW'(1);
    end
  end
`else
  assign w_multi     = 1'b0;
  assign ready_o     = 1'b1;
  assign busy_o      = 1'b0;
  assign w_multiDone = 1'b0;
  assign w_multiRes  = '0;
`endif

  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_c      <= 1'b0;
      r_set    <= 1'b0;
      r_setu   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept && !w_multi) begin
        r_result <= w_aluRes;
        r_valid  <= 1'b1;
        if (w_flagUpd) begin
          r_c    <= w_aluCarry;
          r_set  <= w_lt;
          r_setu <= w_ltu;
        end
      end else if (w_multiDone) begin
        r_result <= w_multiRes;
        r_valid  <= 1'b1;
      end
    end
  end

  assign salida_o      = r_result;
  assign valid_o       = r_valid;
  assign c_o           = r_c;
  assign set_o         = r_set;
  assign setunsigned_o = r_setu;
endmodule
